// File: rtl/sar_ctrl.sv
// sar_ctrl: successive-approximation controller, MSB-first binary search of an N-bit DAC code.
// Optional macro SAR_CTRL_SETTLE_EN: two cycles per step, comparator sampled at the end of the second.
module sar_ctrl #(
    parameter int N             = 8,
    parameter int SAMPLE_CYCLES = 2
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         start,
    input  logic         cmp_gt,
    output logic         sample,
    output logic [N-1:0] dac_code,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result
);

    localparam int SW  = $clog2(N);
    localparam int SCW = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
    localparam logic [SW-1:0]  LAST_STEP   = SW'(N - 1);
    localparam logic [SCW-1:0] LAST_SAMPLE = SCW'(SAMPLE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SAMPLE, CONVERT, DONE} state_t;

    state_t         state;
    logic [SW-1:0]  step;
    logic [SCW-1:0] sample_cnt;
    logic [N-1:0]   trial;
    logic [N-1:0]   kept;
    logic           decide;

    // The bit under test is the only one in dac_code that the comparator can veto.
    assign trial = {{(N-1){1'b0}}, 1'b1} << (LAST_STEP - step);
    assign kept  = cmp_gt ? (dac_code & ~trial) : dac_code;

`ifdef SAR_CTRL_SETTLE_EN
    logic settle_phase;
    assign decide = settle_phase;
`else
    assign decide = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= IDLE;
            step       <= '0;
            sample_cnt <= '0;
            sample     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            dac_code   <= '0;
            result     <= '0;
`ifdef SAR_CTRL_SETTLE_EN
            settle_phase <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= SAMPLE;
                        sample     <= 1'b1;
                        busy       <= 1'b1;
                        sample_cnt <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                SAMPLE: begin
                    if (sample_cnt == LAST_SAMPLE) begin
                        state    <= CONVERT;
                        sample   <= 1'b0;
                        step     <= '0;
                        dac_code <= {1'b1, {(N-1){1'b0}}};
                    end else begin
                        sample_cnt <= sample_cnt + 1'b1;
                    end
                end
                CONVERT: begin
`ifdef SAR_CTRL_SETTLE_EN
                    settle_phase <= ~settle_phase;
`endif
                    if (decide) begin
                        if (step == LAST_STEP) begin
                            state    <= DONE;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            result   <= kept;
                            dac_code <= '0;
                        end else begin
                            step     <= step + 1'b1;
                            dac_code <= kept | (trial >> 1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sar_ctrl.sv
// tb_sar_ctrl: scoreboard bench for sar_ctrl against an ideal comparator (cmp_gt = dac_code > vin).
module tb_sar_ctrl;

    localparam int N = 8;
    localparam int S = 2;
`ifdef SAR_CTRL_SETTLE_EN
    localparam int SC = 2;
`else
    localparam int SC = 1;
`endif
    localparam int CONV_END = S + N * SC;
    localparam int LAT      = CONV_END + 1;

    logic         clk    = 1'b0;
    logic         rstn   = 1'b0;
    logic         start  = 1'b0;
    logic         glitch = 1'b0;
    logic [N-1:0] vin    = '0;
    logic         cmp_gt;
    logic         sample;
    logic         busy;
    logic         done;
    logic [N-1:0] dac_code;
    logic [N-1:0] result;

    int errors = 0;
    int checks = 0;
    logic [N-1:0] exp_q[$];

    assign cmp_gt = (dac_code > vin) ^ glitch;

    always #5 clk = ~clk;

    sar_ctrl #(.N(N), .SAMPLE_CYCLES(S)) dut (
        .clk(clk), .rstn(rstn), .start(start), .cmp_gt(cmp_gt),
        .sample(sample), .dac_code(dac_code), .busy(busy), .done(done), .result(result)
    );

    // Trial code of step k: bits of vin above the trial position plus the trial bit itself.
    function automatic logic [N-1:0] exp_trial(input logic [N-1:0] v, input int k);
        int upper;
        upper = int'(v) & ~((1 << (N - k)) - 1);
        return N'(upper | (1 << (N - 1 - k)));
    endfunction

    task automatic test_reset();
        rstn = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (sample !== 1'b0) begin errors++; $display("[TB] FAIL reset_sample got=%b exp=0", sample); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got=%b exp=0", done); end
        checks++; if (dac_code !== '0) begin errors++; $display("[TB] FAIL reset_dac got=%h exp=00", dac_code); end
        checks++; if (result !== '0) begin errors++; $display("[TB] FAIL reset_result got=%h exp=00", result); end
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if ({sample, busy, done} !== 3'b000) begin errors++; $display("[TB] FAIL reset_idle got=%b exp=000", {sample, busy, done}); end
    endtask

    // Full cycle-by-cycle trace of one conversion; optional start poke in CONVERT and
    // comparator glitch in the first cycle of every step.
    task automatic test_trace(input logic [N-1:0] v, input bit poke, input bit glitchy);
        logic [N-1:0] ev;
        vin = v;
        start = 1'b1;
        exp_q.push_back(v);
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= LAT; c++) begin
            logic [N-1:0] ed;
            logic [2:0]   ectl;
            ectl = {c <= S, c <= CONV_END, c == LAT};
            ed = (c > S && c <= CONV_END) ? exp_trial(v, (c - S - 1) / SC) : '0;
            checks++; if ({sample, busy, done} !== ectl) begin errors++; $display("[TB] FAIL trace_ctrl vin=%h cyc=%0d got=%b exp=%b", v, c, {sample, busy, done}, ectl); end
            checks++; if (dac_code !== ed) begin errors++; $display("[TB] FAIL trace_dac vin=%h cyc=%0d got=%h exp=%h", v, c, dac_code, ed); end
            if (c == LAT) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++; $display("[TB] FAIL trace_scoreboard got=empty exp=entry");
                end else begin
                    ev = exp_q.pop_front();
                    checks++; if (result !== ev) begin errors++; $display("[TB] FAIL trace_result got=%h exp=%h", result, ev); end
                end
            end
            start  = poke && (c == S + 2);
            glitch = glitchy && (c > S) && (c <= CONV_END) && (((c - S - 1) % SC) == 0);
            @(negedge clk);
        end
        glitch = 1'b0;
        checks++; if ({busy, done} !== 2'b00) begin errors++; $display("[TB] FAIL trace_after got=%b exp=00", {busy, done}); end
    endtask

    task automatic test_extremes();
        test_trace(8'h00, 1'b0, 1'b0);
        test_trace(8'hFF, 1'b0, 1'b0);
    endtask

    task automatic test_start_ignored();
        test_trace(8'h69, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] ev;
        logic         exp_done;
        vin = 8'h3C;
        start = 1'b1;
        exp_q.push_back(8'h3C);
        for (int c = 1; c <= 2 * LAT; c++) begin
            @(negedge clk);
            exp_done = (c == LAT) || (c == 2 * LAT);
            checks++; if (done !== exp_done) begin errors++; $display("[TB] FAIL b2b_done cyc=%0d got=%b exp=%b", c, done, exp_done); end
            if (exp_done) begin
                ev = exp_q.pop_front();
                checks++; if (result !== ev) begin errors++; $display("[TB] FAIL b2b_result cyc=%0d got=%h exp=%h", c, result, ev); end
            end
            if (c == LAT) begin
                vin = 8'hC3;
                exp_q.push_back(8'hC3);
            end
            if (c == 2 * LAT) start = 1'b0;
        end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL b2b_idle got=%b exp=0", busy); end
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] ed;
        vin = 8'h96;
        start = 1'b1;
        exp_q.push_back(8'h96);
        @(negedge clk);
        start = 1'b0;
        repeat (S + 3 * SC) @(negedge clk);
        ed = exp_trial(8'h96, 3);
        checks++; if (dac_code !== ed) begin errors++; $display("[TB] FAIL midrst_before got=%h exp=%h", dac_code, ed); end
        rstn = 1'b0;
        @(negedge clk);
        checks++; if ({sample, busy, done, dac_code, result} !== '0) begin errors++; $display("[TB] FAIL midrst_outputs got=%b_%h_%h exp=000_00_00", {sample, busy, done}, dac_code, result); end
        exp_q.delete();
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if ({sample, busy, done} !== 3'b000) begin errors++; $display("[TB] FAIL midrst_idle got=%b exp=000", {sample, busy, done}); end
        test_trace(8'h5A, 1'b0, 1'b0);
    endtask

    task automatic test_exhaustive();
        logic [N-1:0] prev;
        logic [N-1:0] ev;
        bit           got;
        bit           stable;
        prev = result;
        for (int v = 0; v < 256; v++) begin
            vin = N'(v);
            start = 1'b1;
            exp_q.push_back(N'(v));
            @(negedge clk);
            start = 1'b0;
            got = 1'b0;
            stable = 1'b1;
            for (int c = 1; c <= 4 * LAT; c++) begin
                if (done) begin
                    got = 1'b1;
                    break;
                end
                if (result !== prev) stable = 1'b0;
                @(negedge clk);
            end
            if (!got) begin
                checks++; errors++; $display("[TB] FAIL exh_timeout vin=%h got=no_done exp=done", N'(v));
                exp_q.delete();
            end else begin
                ev = exp_q.pop_front();
                checks++; if (result !== ev) begin errors++; $display("[TB] FAIL exh_result got=%h exp=%h", result, ev); end
                checks++; if (!stable) begin errors++; $display("[TB] FAIL exh_stable vin=%h got=changed exp=held_%h", N'(v), prev); end
            end
            prev = result;
        end
        @(negedge clk);
    endtask

`ifdef SAR_CTRL_SETTLE_EN
    task automatic test_settle_glitch();
        test_trace(8'hA5, 1'b0, 1'b1);
    endtask
`endif

    initial begin
        test_reset();
        test_trace(8'hA5, 1'b0, 1'b0);
        test_extremes();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
        test_exhaustive();
`ifdef SAR_CTRL_SETTLE_EN
        test_settle_glitch();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
